// File: rtl/prod_window_acc_if.sv
// Product stream in, window statistics out.
// Both handshakes share one bundle; master is the upstream/downstream side.
interface prod_window_acc_if #(
    parameter int w = 4
);
    logic [2*w-1:0] in;
    logic           in_valid;
    logic           in_ready;
    logic           flush;
    logic [2*w+3:0] out_sum;
    logic [2*w-1:0] out_max;
    logic [3:0]     out_cnt;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in, in_valid, flush, out_ready,
        input  in_ready, out_sum, out_max, out_cnt, out_valid
    );

    modport slave (
        input  in, in_valid, flush, out_ready,
        output in_ready, out_sum, out_max, out_cnt, out_valid
    );
endinterface

// File: rtl/prod_window_acc.sv
// Sums and max-tracks products over an n-sample window,
// then holds the result until downstream takes it.
module prod_window_acc #(
    parameter int w = 4,
    parameter int n = 4
) (
    input logic clk,
    input logic rst,
    prod_window_acc_if.slave bus
);
    localparam int SW = 2 * w + 4;
    localparam logic [3:0] LAST = 4'(n - 1);

    typedef enum logic {ACC, HOLD} state_t;

    state_t state;
    state_t state_nx;

    logic [SW-1:0]  acc;
    logic [2*w-1:0] mx;
    logic [3:0]     cnt;
    logic [SW-1:0]  o_sum;
    logic [2*w-1:0] o_max;
    logic [3:0]     o_cnt;
    logic           o_valid;

    logic           rdy;
    logic           accept;
    logic           close;
    logic           take;
    logic [SW-1:0]  sum_nx;
    logic [2*w-1:0] mx_nx;
    logic [3:0]     cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ACC:  if (close) state_nx = HOLD;
            HOLD: if (bus.out_ready) state_nx = ACC;
            default: state_nx = ACC;
        endcase
    end

    always_comb begin
        rdy  = (state == ACC);
        take = (state == HOLD) & bus.out_ready;
    end

    always_comb begin
        accept = bus.in_valid & rdy;
        sum_nx = acc + (accept ? SW'(bus.in) : '0);
        mx_nx  = (accept && bus.in > mx) ? bus.in : mx;
        cnt_nx = cnt + {3'b000, accept};
        // An empty window never closes, even on flush.
        close  = rdy & ((accept & (cnt == LAST))
               | (bus.flush & (accept | (cnt != 4'd0))));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mx      <= '0;
            cnt     <= '0;
            o_sum   <= '0;
            o_max   <= '0;
            o_cnt   <= '0;
            o_valid <= 1'b0;
        end else if (close) begin
            o_sum   <= sum_nx;
            o_max   <= mx_nx;
            o_cnt   <= cnt_nx;
            o_valid <= 1'b1;
            acc     <= '0;
            mx      <= '0;
            cnt     <= '0;
        end else if (accept) begin
            acc <= sum_nx;
            mx  <= mx_nx;
            cnt <= cnt_nx;
        end else if (take) begin
            o_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_sum   = o_sum;
    assign bus.out_max   = o_max;
    assign bus.out_cnt   = o_cnt;
    assign bus.out_valid = o_valid;
endmodule

// File: tb/tb_prod_window_acc.sv
// Directed vectors for prod_window_acc: a w=4/n=4 table
// plus hand sequences for HOLD reset and the n=1 case.
module tb_prod_window_acc;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prod_window_acc_if #(.w(4)) bus_a ();
    prod_window_acc_if #(.w(6)) bus_b ();

    prod_window_acc #(.w(4), .n(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    prod_window_acc #(.w(6), .n(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    typedef struct {
        logic        r;
        logic [7:0]  d;
        logic        v;
        logic        f;
        logic        ordy;
        logic        e_valid;
        logic [11:0] e_sum;
        logic [7:0]  e_max;
        logic [3:0]  e_cnt;
        logic        e_ready;
    } vec_t;

    vec_t tbl[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic vec_t mk(
        logic r, logic [7:0] d, logic v, logic f, logic ordy,
        logic ev, logic [11:0] es, logic [7:0] em,
        logic [3:0] ec, logic er
    );
        vec_t t;
        t.r = r; t.d = d; t.v = v; t.f = f; t.ordy = ordy;
        t.e_valid = ev; t.e_sum = es; t.e_max = em;
        t.e_cnt = ec; t.e_ready = er;
        return t;
    endfunction

    task automatic chk_a(
        string name, logic ev, logic [11:0] es,
        logic [7:0] em, logic [3:0] ec, logic er
    );
        n_cmp++;
        if (bus_a.out_valid !== ev || bus_a.out_sum !== es ||
            bus_a.out_max !== em || bus_a.out_cnt !== ec ||
            bus_a.in_ready !== er) begin
            n_bad++;
            $display("FAIL %s: got v=%0b sum=%0d max=%0d cnt=%0d rdy=%0b want v=%0b sum=%0d max=%0d cnt=%0d rdy=%0b",
                name, bus_a.out_valid, bus_a.out_sum, bus_a.out_max,
                bus_a.out_cnt, bus_a.in_ready, ev, es, em, ec, er);
        end
    endtask

    task automatic chk_b(
        string name, logic ev, logic [15:0] es,
        logic [11:0] em, logic [3:0] ec, logic er
    );
        n_cmp++;
        if (bus_b.out_valid !== ev || bus_b.out_sum !== es ||
            bus_b.out_max !== em || bus_b.out_cnt !== ec ||
            bus_b.in_ready !== er) begin
            n_bad++;
            $display("FAIL %s: got v=%0b sum=%0d max=%0d cnt=%0d rdy=%0b want v=%0b sum=%0d max=%0d cnt=%0d rdy=%0b",
                name, bus_b.out_valid, bus_b.out_sum, bus_b.out_max,
                bus_b.out_cnt, bus_b.in_ready, ev, es, em, ec, er);
        end
    endtask

    task automatic drive_a(logic [7:0] d, logic v, logic f, logic o);
        bus_a.in = d;
        bus_a.in_valid = v;
        bus_a.flush = f;
        bus_a.out_ready = o;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive_a(8'd0, 1'b0, 1'b0, 1'b0);
        bus_b.in = '0;
        bus_b.in_valid = 1'b0;
        bus_b.flush = 1'b0;
        bus_b.out_ready = 1'b1;

        //           r  d    v  f  o   ev sum  max cnt rdy
        tbl.push_back(mk(1, 0,   0, 0, 0,  0, 0,   0,  0, 1));
        tbl.push_back(mk(0, 50,  1, 0, 0,  0, 0,   0,  0, 1));
        tbl.push_back(mk(0, 25,  1, 0, 0,  0, 0,   0,  0, 1));
        tbl.push_back(mk(0, 10,  1, 0, 0,  0, 0,   0,  0, 1));
        tbl.push_back(mk(0, 0,   1, 0, 0,  1, 85,  50, 4, 0));
        tbl.push_back(mk(0, 99,  1, 0, 0,  1, 85,  50, 4, 0));
        tbl.push_back(mk(0, 99,  0, 0, 0,  1, 85,  50, 4, 0));
        tbl.push_back(mk(0, 99,  1, 1, 0,  1, 85,  50, 4, 0));
        tbl.push_back(mk(0, 0,   0, 0, 1,  0, 85,  50, 4, 1));
        tbl.push_back(mk(0, 225, 1, 0, 0,  0, 85,  50, 4, 1));
        tbl.push_back(mk(0, 225, 1, 0, 0,  0, 85,  50, 4, 1));
        tbl.push_back(mk(0, 225, 1, 0, 0,  0, 85,  50, 4, 1));
        tbl.push_back(mk(0, 225, 1, 0, 0,  1, 900, 225, 4, 0));
        tbl.push_back(mk(0, 0,   0, 0, 1,  0, 900, 225, 4, 1));
        tbl.push_back(mk(0, 65,  1, 0, 0,  0, 900, 225, 4, 1));
        tbl.push_back(mk(0, 169, 1, 0, 0,  0, 900, 225, 4, 1));
        tbl.push_back(mk(0, 0,   0, 1, 0,  1, 234, 169, 2, 0));
        tbl.push_back(mk(0, 0,   0, 0, 1,  0, 234, 169, 2, 1));
        tbl.push_back(mk(0, 65,  1, 0, 0,  0, 234, 169, 2, 1));
        tbl.push_back(mk(0, 169, 1, 0, 0,  0, 234, 169, 2, 1));
        tbl.push_back(mk(0, 10,  1, 1, 0,  1, 244, 169, 3, 0));
        tbl.push_back(mk(0, 0,   0, 0, 1,  0, 244, 169, 3, 1));
        tbl.push_back(mk(0, 0,   0, 1, 1,  0, 244, 169, 3, 1));
        tbl.push_back(mk(0, 10,  1, 0, 0,  0, 244, 169, 3, 1));
        tbl.push_back(mk(0, 20,  1, 0, 0,  0, 244, 169, 3, 1));
        tbl.push_back(mk(1, 30,  1, 0, 0,  0, 0,   0,  0, 1));
        tbl.push_back(mk(0, 1,   1, 0, 0,  0, 0,   0,  0, 1));
        tbl.push_back(mk(0, 1,   1, 0, 0,  0, 0,   0,  0, 1));
        tbl.push_back(mk(0, 1,   1, 0, 0,  0, 0,   0,  0, 1));
        tbl.push_back(mk(0, 1,   1, 0, 0,  1, 4,   1,  4, 0));
        tbl.push_back(mk(0, 7,   1, 0, 1,  0, 4,   1,  4, 1));
        tbl.push_back(mk(0, 7,   1, 0, 0,  0, 4,   1,  4, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r;
            drive_a(tbl[i].d, tbl[i].v, tbl[i].f, tbl[i].ordy);
            step();
            chk_a($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_sum,
                  tbl[i].e_max, tbl[i].e_cnt, tbl[i].e_ready);
        end

        // Fill the pending window, then reset while in HOLD.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_a(8'd1, 1'b1, 1'b0, 1'b0);
            step();
        end
        chk_a("hold_fill", 1'b1, 12'd10, 8'd7, 4'd4, 1'b0);
        drive_a(8'd5, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        chk_a("hold_rst", 1'b0, 12'd0, 8'd0, 4'd0, 1'b1);
        rst = 1'b0;
        drive_a(8'd0, 1'b0, 1'b0, 1'b0);

        // n=1: each accepted sample is its own window.
        chk_b("b_reset", 1'b0, 16'd0, 12'd0, 4'd0, 1'b1);
        bus_b.in = 12'd3969;
        bus_b.in_valid = 1'b1;
        step();
        chk_b("b_w1", 1'b1, 16'd3969, 12'd3969, 4'd1, 1'b0);
        bus_b.in = 12'd0;
        step();
        chk_b("b_gap", 1'b0, 16'd3969, 12'd3969, 4'd1, 1'b1);
        step();
        chk_b("b_w2", 1'b1, 16'd0, 12'd0, 4'd1, 1'b0);
        bus_b.in_valid = 1'b0;
        step();
        chk_b("b_idle", 1'b0, 16'd0, 12'd0, 4'd1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
